// File: rtl/prog_ctr_rs_pkg.sv
// Shared types for the fetch-stage program counter: the per-cycle operation
// and the priority decode that picks it from the control flags.
package prog_ctr_rs_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_BR_ABS,
        OP_BR_REL,
        OP_CALL,
        OP_RET,
        OP_ILLEGAL
    } pc_op_e;

    // Stall wins over everything except reset; call/ret may not be combined
    // with each other or with a branch.
    function automatic pc_op_e decode_op(input logic stall, input logic branch,
                                         input logic rel, input logic call,
                                         input logic ret);
        pc_op_e op;
        if (stall)
            op = OP_HOLD;
        else if ((call && ret) || ((call || ret) && branch))
            op = OP_ILLEGAL;
        else if (ret)
            op = OP_RET;
        else if (call)
            op = OP_CALL;
        else if (branch)
            op = rel ? OP_BR_REL : OP_BR_ABS;
        else
            op = OP_INC;
        return op;
    endfunction

endpackage

// File: rtl/prog_ctr_rs_if.sv
// Control/status bundle between fetch control decode and the program counter.
interface prog_ctr_rs_if #(
    parameter int PC_W = 9
);
    logic            stall;
    logic            branch;
    logic            rel;
    logic            call;
    logic            ret;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] prog_ctr;
    logic            ras_empty;
    logic            ras_full;
    logic            fault;

    modport master (
        output stall, branch, rel, call, ret, target,
        input  prog_ctr, ras_empty, ras_full, fault
    );

    modport slave (
        input  stall, branch, rel, call, ret, target,
        output prog_ctr, ras_empty, ras_full, fault
    );
endinterface

// File: rtl/prog_ctr_rs_ret_stack.sv
// Return-address stack: register array plus occupancy count. The parent
// guarantees push and pop are never asserted in the same cycle.
module prog_ctr_rs_ret_stack #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         start,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [W-1:0]  masked  [DEPTH];
    logic [CW-1:0] count_reg;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (start) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    // Entries are not cleared on start; the count alone decides what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!start && push && !full && count_reg == CW'(i))
                mem_reg[i] <= push_data;
        end
    end

    // Only the entry at count-1 survives the mask, so an empty stack reads 0.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_top_sel
            assign masked[gi] = (count_reg == CW'(gi + 1)) ? mem_reg[gi] : '0;
        end
    endgenerate

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            top = top | masked[i];
    end

endmodule

// File: rtl/prog_ctr_rs.sv
// Fetch-stage program counter with increment, stall, absolute/relative
// branch and call/return through a return-address stack; faults are sticky.
module prog_ctr_rs
    import prog_ctr_rs_pkg::*;
#(
    parameter int PC_W       = 9,
    parameter int RAS_DEPTH  = 4,
    parameter int START_ADDR = 0
) (
    input  logic          clk,
    input  logic          start,
    prog_ctr_rs_if.slave  bus
);
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            fault_reg, fault_next;
    logic            push, pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_full;
    pc_op_e          op;

    assign op = decode_op(bus.stall, bus.branch, bus.rel, bus.call, bus.ret);

    always_comb begin
        pc_next    = pc_reg;
        fault_next = fault_reg;
        push       = 1'b0;
        pop        = 1'b0;
        case (op)
            OP_HOLD:    ;
            OP_ILLEGAL: fault_next = 1'b1;
            OP_RET: begin
                if (ras_empty) begin
                    fault_next = 1'b1;
                end else begin
                    pc_next = ras_top;
                    pop     = 1'b1;
                end
            end
            OP_CALL: begin
                if (ras_full) begin
                    fault_next = 1'b1;
                end else begin
                    pc_next = bus.target;
                    push    = 1'b1;
                end
            end
            OP_BR_ABS: pc_next = bus.target;
            // Two's-complement add at PC_W bits wraps in both directions.
            OP_BR_REL: pc_next = pc_reg + bus.target;
            default:   pc_next = pc_reg + PC_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (start) begin
            pc_reg    <= PC_W'(START_ADDR);
            fault_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            fault_reg <= fault_next;
        end
    end

    prog_ctr_rs_ret_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .start     (start),
        .push      (push),
        .pop       (pop),
        .push_data (pc_reg + PC_W'(1)),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign bus.prog_ctr  = pc_reg;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.fault     = fault_reg;

endmodule

// File: tb/tb_prog_ctr_rs.sv
// Directed bench for prog_ctr_rs: a queue-based reference model checked every
// cycle, plus literal expectations for the hand-worked scenarios.
module tb_prog_ctr_rs;
    localparam int PC_W       = 9;
    localparam int RAS_DEPTH  = 4;
    localparam int START_ADDR = 0;
    localparam int MOD        = 1 << PC_W;

    logic clk = 1'b0;
    logic start;
    always #5 clk = ~clk;

    prog_ctr_rs_if #(.PC_W(PC_W)) bus ();

    prog_ctr_rs #(
        .PC_W       (PC_W),
        .RAS_DEPTH  (RAS_DEPTH),
        .START_ADDR (START_ADDR)
    ) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    int m_pc    = 0;
    int m_ras[$];
    bit m_fault = 1'b0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the architectural rules applied to integers and a queue.
    always @(posedge clk) begin
        int off;
        if (start) begin
            m_pc    = START_ADDR;
            m_fault = 1'b0;
            m_ras.delete();
        end else if (bus.stall) begin
        end else if ((bus.call && bus.ret) || ((bus.call || bus.ret) && bus.branch)) begin
            m_fault = 1'b1;
        end else if (bus.ret) begin
            if (m_ras.size() == 0) m_fault = 1'b1;
            else m_pc = m_ras.pop_back();
        end else if (bus.call) begin
            if (m_ras.size() == RAS_DEPTH) m_fault = 1'b1;
            else begin
                m_ras.push_back((m_pc + 1) % MOD);
                m_pc = int'(bus.target);
            end
        end else if (bus.branch) begin
            if (bus.rel) begin
                off  = (int'(bus.target) >= MOD / 2) ? int'(bus.target) - MOD : int'(bus.target);
                m_pc = ((m_pc + off) % MOD + MOD) % MOD;
            end else begin
                m_pc = int'(bus.target);
            end
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_pc",    int'(bus.prog_ctr),  m_pc);
            chk("model_empty", int'(bus.ras_empty), (m_ras.size() == 0) ? 1 : 0);
            chk("model_full",  int'(bus.ras_full),  (m_ras.size() == RAS_DEPTH) ? 1 : 0);
            chk("model_fault", int'(bus.fault),     int'(m_fault));
        end
    end

    task automatic step(input logic s, input logic st, input logic br, input logic rl,
                        input logic ca, input logic rt, input int tg, input string tag);
        start      = s;
        bus.stall  = st;
        bus.branch = br;
        bus.rel    = rl;
        bus.call   = ca;
        bus.ret    = rt;
        bus.target = PC_W'(tg);
        @(negedge clk);
        txn++;
        $display("txn %0d %s pc=%0d empty=%0b full=%0b fault=%0b",
                 txn, tag, bus.prog_ctr, bus.ras_empty, bus.ras_full, bus.fault);
    endtask

    task automatic inc();   step(0, 0, 0, 0, 0, 0, 0,  "inc");   endtask
    task automatic rst();   step(1, 0, 0, 0, 0, 0, 0,  "start"); endtask
    task automatic ret_op(); step(0, 0, 0, 0, 0, 1, 0, "ret");   endtask
    task automatic call_op(input int tg); step(0, 0, 0, 0, 1, 0, tg, "call"); endtask
    task automatic br_abs(input int tg);  step(0, 0, 1, 0, 0, 0, tg, "br_abs"); endtask
    task automatic br_rel(input int tg);  step(0, 0, 1, 1, 0, 0, tg, "br_rel"); endtask

    initial begin
        // 1. reset and free run
        rst();
        chk("reset_pc", int'(bus.prog_ctr), 0);
        chk("reset_empty", int'(bus.ras_empty), 1);
        chk("reset_full", int'(bus.ras_full), 0);
        chk("reset_fault", int'(bus.fault), 0);
        for (int k = 1; k <= 10; k++) begin
            inc();
            chk("free_run_pc", int'(bus.prog_ctr), k);
        end

        // 2. branches and top-end wrap
        br_abs(100);
        chk("br_abs_pc", int'(bus.prog_ctr), 100);
        br_rel(-4);
        chk("br_rel_back_pc", int'(bus.prog_ctr), 96);
        br_abs(511);
        inc();
        chk("inc_wrap_pc", int'(bus.prog_ctr), 0);

        // 3. nested call/return
        br_abs(20);
        call_op(200);
        chk("call1_pc", int'(bus.prog_ctr), 200);
        chk("call1_empty", int'(bus.ras_empty), 0);
        call_op(300 % MOD);
        chk("call2_pc", int'(bus.prog_ctr), 300);
        ret_op();
        chk("ret1_pc", int'(bus.prog_ctr), 201);
        ret_op();
        chk("ret2_pc", int'(bus.prog_ctr), 21);
        chk("ret2_empty", int'(bus.ras_empty), 1);
        chk("ret2_fault", int'(bus.fault), 0);

        // 4. fill the stack, overflow call
        call_op(10);
        call_op(20);
        call_op(30);
        call_op(40);
        chk("fill_full", int'(bus.ras_full), 1);
        chk("fill_pc", int'(bus.prog_ctr), 40);
        call_op(50);
        chk("overflow_fault", int'(bus.fault), 1);
        chk("overflow_pc", int'(bus.prog_ctr), 40);
        ret_op();
        chk("after_overflow_ret_pc", int'(bus.prog_ctr), 31);
        chk("after_overflow_full", int'(bus.ras_full), 0);

        // 5. empty pop, illegal combos, stall
        rst();
        chk("restart_fault", int'(bus.fault), 0);
        inc();
        ret_op();
        chk("ret_empty_fault", int'(bus.fault), 1);
        chk("ret_empty_pc", int'(bus.prog_ctr), 1);
        call_op(7);
        step(0, 0, 0, 0, 1, 1, 99, "call_ret");
        chk("call_ret_pc", int'(bus.prog_ctr), 7);
        chk("call_ret_empty", int'(bus.ras_empty), 0);
        step(0, 0, 1, 0, 0, 1, 99, "br_ret");
        chk("br_ret_pc", int'(bus.prog_ctr), 7);
        step(0, 1, 1, 0, 0, 0, 100, "stall_br");
        chk("stall_pc", int'(bus.prog_ctr), 7);
        ret_op();
        chk("ret_after_illegal_pc", int'(bus.prog_ctr), 2);

        // 6. start discards a populated stack and a set fault
        step(1, 1, 0, 0, 0, 0, 0, "start_stall");
        chk("start_over_stall_pc", int'(bus.prog_ctr), START_ADDR);
        call_op(50);
        call_op(60);
        step(0, 0, 1, 0, 1, 0, 5, "call_br");
        chk("call_br_fault", int'(bus.fault), 1);
        chk("call_br_pc", int'(bus.prog_ctr), 60);
        rst();
        chk("t6_pc", int'(bus.prog_ctr), START_ADDR);
        chk("t6_empty", int'(bus.ras_empty), 1);
        chk("t6_fault", int'(bus.fault), 0);
        ret_op();
        chk("t6_ret_fault", int'(bus.fault), 1);
        chk("t6_ret_pc", int'(bus.prog_ctr), START_ADDR);
        br_rel(-1);
        chk("rel_wrap_down_pc", int'(bus.prog_ctr), 511);
        br_rel(3);
        chk("rel_wrap_up_pc", int'(bus.prog_ctr), 2);
        inc();
        chk("final_inc_pc", int'(bus.prog_ctr), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
